// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction-fetch stage pairing in-order memory responses with their PCs and queuing them toward decode
//
// Ports:
//    clock, reset          rising-edge clock, asynchronous active-low reset
//    pc_in/pc_valid/pc_ready                  fetch address from PC (PC holds while pc_ready is low)
//    flush                                    taken-branch redirect, drops everything older than this cycle
//    imem_req_valid/imem_req_addr/imem_req_ready  request channel to instruction memory
//    imem_resp_valid/imem_resp_data           in-order responses from instruction memory
//    inst_valid/inst_data/inst_pc/inst_ready  FIFO head toward decode
//
// Optional feature: define IFQ_BYPASS_EN to forward a response straight to decode when the FIFO is empty.
module ifetch_queue #(
   parameter int DEPTH           = 4,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] pc_in,
   input  logic        pc_valid,
   output logic        pc_ready,
   input  logic        flush,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        inst_valid,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   input  logic        inst_ready
);
   localparam int AW  = $clog2(DEPTH);
   localparam int PW  = AW + 1;
   // a single-entry tag queue still gets a 1-bit index so the pointer scheme stays uniform
   localparam int TW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int TPW = TW + 1;
   localparam int TN  = 1 << TW;
   localparam int OW  = $clog2(MAX_OUTSTANDING + 1);

   logic [PW-1:0]  wr, rd, count;
   logic [TPW-1:0] t_wr, t_rd;
   logic [OW-1:0]  outstanding, drop_cnt;
   logic [31:0]    f_pc [DEPTH];
   logic [31:0]    f_data [DEPTH];
   logic [31:0]    tag_q [TN];
   logic [31:0]    used, tag_head, head_pc, head_data;
   logic           fifo_empty, tag_empty, has_credit, room;
   logic           req_fire, resp_take, out_dec, fifo_push, fifo_pop, byp;

   assign fifo_empty = (wr == rd);
   assign count      = wr - rd;
   assign tag_empty  = (t_wr == t_rd);
   assign tag_head   = tag_q[t_rd[TW-1:0]];
   assign head_pc    = f_pc[rd[AW-1:0]];
   assign head_data  = f_data[rd[AW-1:0]];
   // credit counts in-flight requests as already occupying FIFO slots, so a response always has room
   assign used       = 32'(count) + 32'(outstanding);
   assign has_credit = used < 32'(DEPTH);
   assign room       = 32'(outstanding) < 32'(MAX_OUTSTANDING);

   assign imem_req_valid = reset & pc_valid & has_credit & room & ~flush;
   assign imem_req_addr  = pc_in;
   assign pc_ready       = imem_req_valid & imem_req_ready;
   assign req_fire       = pc_ready;

   // a response with an empty tag queue is unsolicited (e.g. issued before a reset) and is dropped
   assign resp_take = imem_resp_valid & (drop_cnt == '0) & ~tag_empty & ~flush;
   assign out_dec   = imem_resp_valid & (outstanding != '0);
   assign fifo_pop  = ~fifo_empty & inst_ready & ~flush;

`ifdef IFQ_BYPASS_EN
   always_comb begin
      byp        = resp_take & fifo_empty;
      inst_valid = ~fifo_empty | byp;
      inst_data  = ~fifo_empty ? head_data : byp ? imem_resp_data : '0;
      inst_pc    = ~fifo_empty ? head_pc : byp ? tag_head : '0;
      fifo_push  = resp_take & ~(byp & inst_ready);
   end
`else
   always_comb begin
      byp        = 1'b0;
      inst_valid = ~fifo_empty;
      inst_data  = fifo_empty ? '0 : head_data;
      inst_pc    = fifo_empty ? '0 : head_pc;
      fifo_push  = resp_take & ~byp;
   end
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr          <= '0;
         rd          <= '0;
         t_wr        <= '0;
         t_rd        <= '0;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         outstanding <= outstanding + OW'(req_fire) - OW'(out_dec);
         t_wr        <= t_wr + TPW'(req_fire);
         if (flush) begin
            rd       <= wr;
            t_rd     <= t_wr;
            // everything still in flight after this cycle's response belongs to the wrong path
            drop_cnt <= outstanding - OW'(out_dec);
         end else begin
            wr       <= wr + PW'(fifo_push);
            rd       <= rd + PW'(fifo_pop);
            t_rd     <= t_rd + TPW'(resp_take);
            drop_cnt <= drop_cnt - OW'(imem_resp_valid && drop_cnt != '0);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (fifo_push) begin
         f_pc[wr[AW-1:0]]   <= tag_head;
         f_data[wr[AW-1:0]] <= imem_resp_data;
      end
      if (req_fire)
         tag_q[t_wr[TW-1:0]] <= pc_in;
   end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed self-checking bench for ifetch_queue
module tb_ifetch_queue;
   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] pc_in;
   logic        pc_valid;
   logic        pc_ready;
   logic        flush;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        inst_ready;
   int          checks = 0;
   int          errors = 0;

   ifetch_queue #(.DEPTH(4), .MAX_OUTSTANDING(2)) dut (
      .clock(clock), .reset(reset), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
      .flush(flush), .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
      .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
      .imem_resp_data(imem_resp_data), .inst_valid(inst_valid), .inst_data(inst_data),
      .inst_pc(inst_pc), .inst_ready(inst_ready)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] memw(input logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic nxt;
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic pv, input logic [31:0] pc, input logic rv, input logic [31:0] rd,
                        input logic fl, input logic ir);
      pc_valid = pv; pc_in = pc; imem_resp_valid = rv; imem_resp_data = rd; flush = fl; inst_ready = ir;
      #1;
   endtask

   initial begin
      #90000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] exp_pc [3];
      exp_pc[0] = 32'h8; exp_pc[1] = 32'hC; exp_pc[2] = 32'h10;
      reset = 1'b0; imem_req_ready = 1'b1;
      drive(1, 32'h0, 0, 0, 0, 0);
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_pc_ready", pc_ready, 0);
      chk("rst_inst_valid", inst_valid, 0);
      chk("rst_inst_data", inst_data, 0);
      chk("rst_inst_pc", inst_pc, 0);
      nxt;
      reset = 1'b1;
      // streaming fetch with 1-cycle memory latency
      drive(1, 32'h0, 0, 0, 0, 0);
      chk("s_req0_valid", imem_req_valid, 1);
      chk("s_req0_addr", imem_req_addr, 32'h0);
      nxt;
      drive(1, 32'h4, 1, memw(32'h0), 0, 0);
      chk("s_req1_ready", pc_ready, 1);
      chk("s_req1_addr", imem_req_addr, 32'h4);
`ifdef IFQ_BYPASS_EN
      chk("s_byp_valid", inst_valid, 1);
`else
      chk("s_lat_valid", inst_valid, 0);
`endif
      nxt;
      drive(1, 32'h8, 1, memw(32'h4), 0, 0);
      chk("s_req2_ready", pc_ready, 1);
      chk("s_head_valid", inst_valid, 1);
      chk("s_head_pc", inst_pc, 32'h0);
      chk("s_head_data", inst_data, memw(32'h0));
      nxt;
      drive(1, 32'hC, 1, memw(32'h8), 0, 0);
      chk("s_req3_ready", pc_ready, 1);
      nxt;
      drive(1, 32'h10, 1, memw(32'hC), 0, 0);
      chk("bp_req_valid", imem_req_valid, 0);
      chk("bp_pc_ready", pc_ready, 0);
      nxt;
      drive(1, 32'h10, 0, 0, 0, 1);
      chk("bp_full_valid", imem_req_valid, 0);
      chk("bp_pop_pc", inst_pc, 32'h0);
      nxt;
      drive(1, 32'h10, 0, 0, 0, 0);
      chk("bp_one_more", pc_ready, 1);
      chk("bp_one_addr", imem_req_addr, 32'h10);
      chk("bp_next_head", inst_pc, 32'h4);
      nxt;
      drive(1, 32'h14, 0, 0, 0, 0);
      chk("bp_only_one", imem_req_valid, 0);
      nxt;
      drive(0, 32'h14, 1, memw(32'h10), 0, 1);
      chk("dr_pc_4", inst_pc, 32'h4);
      nxt;
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 0, 0, 1);
         chk("dr_pc", inst_pc, exp_pc[i]);
         nxt;
      end
      drive(0, 0, 0, 0, 0, 0);
      chk("dr_empty", inst_valid, 0);
      // flush with two requests in flight, no response in the flush cycle
      drive(1, 32'h10, 0, 0, 0, 0);
      nxt;
      drive(1, 32'h14, 0, 0, 0, 0);
      chk("f1_req14", pc_ready, 1);
      nxt;
      drive(1, 32'h18, 0, 0, 1, 0);
      chk("f1_flush_req", imem_req_valid, 0);
      chk("f1_flush_rdy", pc_ready, 0);
      nxt;
      drive(1, 32'h40, 1, memw(32'h10), 0, 0);
      chk("f1_maxout", imem_req_valid, 0);
      chk("f1_drop10", inst_valid, 0);
      nxt;
      drive(1, 32'h40, 1, memw(32'h14), 0, 0);
      chk("f1_tgt_req", pc_ready, 1);
      chk("f1_tgt_addr", imem_req_addr, 32'h40);
      chk("f1_drop14", inst_valid, 0);
      nxt;
      drive(0, 0, 1, memw(32'h40), 0, 0);
`ifdef IFQ_BYPASS_EN
      chk("f1_byp40", inst_pc, 32'h40);
`else
      chk("f1_notyet", inst_valid, 0);
`endif
      nxt;
      drive(0, 0, 0, 0, 0, 1);
      chk("f1_valid40", inst_valid, 1);
      chk("f1_pc40", inst_pc, 32'h40);
      chk("f1_data40", inst_data, memw(32'h40));
      nxt;
      drive(0, 0, 0, 0, 0, 0);
      chk("f1_empty", inst_valid, 0);
      // flush coinciding with the first response, second still outstanding
      drive(1, 32'h10, 0, 0, 0, 0);
      nxt;
      drive(1, 32'h14, 0, 0, 0, 0);
      nxt;
      drive(0, 0, 1, memw(32'h10), 1, 0);
      chk("f2_flush_cyc", inst_valid, 0);
      nxt;
      drive(0, 0, 1, memw(32'h14), 0, 0);
      chk("f2_drop14", inst_valid, 0);
      nxt;
      drive(1, 32'h80, 0, 0, 0, 0);
      chk("f2_empty", inst_valid, 0);
      chk("f2_restart", pc_ready, 1);
      nxt;
      drive(0, 0, 1, memw(32'h80), 0, 0);
      nxt;
      drive(0, 0, 0, 0, 0, 1);
      chk("f2_pc80", inst_pc, 32'h80);
      nxt;
      drive(0, 0, 0, 0, 0, 0);
      chk("f2_drained", inst_valid, 0);
      // asynchronous reset with three entries queued and one request in flight
      drive(1, 32'h100, 0, 0, 0, 0);
      nxt;
      drive(1, 32'h104, 1, memw(32'h100), 0, 0);
      nxt;
      drive(1, 32'h108, 1, memw(32'h104), 0, 0);
      nxt;
      drive(1, 32'h10C, 1, memw(32'h108), 0, 0);
      nxt;
      drive(1, 32'h110, 0, 0, 0, 0);
      chk("r_full", imem_req_valid, 0);
      chk("r_head", inst_pc, 32'h100);
      reset = 1'b0;
      #1;
      chk("r_async_valid", inst_valid, 0);
      chk("r_async_rdy", pc_ready, 0);
      chk("r_async_pc", inst_pc, 0);
      nxt;
      nxt;
      reset = 1'b1;
      drive(0, 0, 1, memw(32'h10C), 0, 0);
      chk("r_unsol", inst_valid, 0);
      nxt;
      drive(1, 32'h200, 0, 0, 0, 0);
      chk("r_unsol_drop", inst_valid, 0);
      chk("r_restart", pc_ready, 1);
      chk("r_restart_addr", imem_req_addr, 32'h200);
      nxt;
      drive(0, 0, 1, memw(32'h200), 0, 0);
      nxt;
      drive(0, 0, 0, 0, 0, 1);
      chk("r_pc200", inst_pc, 32'h200);
      chk("r_data200", inst_data, memw(32'h200));
      nxt;
      // response into an empty FIFO with decode ready
      drive(1, 32'h300, 0, 0, 0, 1);
      chk("b_empty", inst_valid, 0);
      nxt;
      drive(0, 0, 1, 32'h8C0A0004, 0, 1);
`ifdef IFQ_BYPASS_EN
      chk("b_same_valid", inst_valid, 1);
      chk("b_same_data", inst_data, 32'h8C0A0004);
      chk("b_same_pc", inst_pc, 32'h300);
      nxt;
      drive(0, 0, 0, 0, 0, 1);
      chk("b_not_stored", inst_valid, 0);
`else
      chk("b_no_comb", inst_valid, 0);
      nxt;
      drive(0, 0, 0, 0, 0, 1);
      chk("b_reg_data", inst_data, 32'h8C0A0004);
      chk("b_reg_pc", inst_pc, 32'h300);
      nxt;
      drive(0, 0, 0, 0, 0, 1);
      chk("b_popped", inst_valid, 0);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
